// File: rtl/stash_pkg.sv
// Shared definitions for the op1/op2 stash paths: drain FSM encoding, tuser
// field offsets and protocol constants also used by the input filter.
package stash_pkg;

    // Drain FSM encoding, exposed on o_dbg_state of the drain stage
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Destination-port byte inside tuser
    localparam int TUSER_DST_LO = 24;
    localparam int TUSER_DST_HI = 31;

    // Constants shared with the input filter
    localparam logic [7:0]  DST_PORT_OP1 = 8'h04;
    localparam logic [7:0]  IPPROT_UDP   = 8'h11;
    localparam logic [15:0] INET         = 16'h0800;

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry output buffer (main register + skid register) for an AXI4-Stream
// master. The producer must not push while skid_full is high; the buffer then
// absorbs at most two beats while the consumer stalls.
// Handshake: a beat transfers on out_valid && out_ready; out_valid and
// out_data hold steady while out_valid && !out_ready.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             skid_full,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;
    logic             out_fire;

    assign out_fire  = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign skid_full = skid_valid;

    // Main reloads whenever it is empty or drained, oldest beat (skid) first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (!main_valid || out_fire) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                main_valid <= 1'b1;
                if (in_valid) begin
                    skid_data <= in_data;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else begin
                main_valid <= in_valid;
                if (in_valid) begin
                    main_data <= in_data;
                end
            end
        end else if (in_valid) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/stash_op1_out.sv
// Drain stage of the op1 stash path: pops the FWFT packet FIFO, rewrites the
// destination-port byte of the first beat, truncates packets longer than
// MAX_BEATS (remaining beats are popped silently) and drives an AXI4-Stream
// master through a two-entry skid buffer.
// Optional: define STASH_OP1_OUT_STATS_EN to build the packet/truncation
// counters; otherwise o_pkt_cnt and o_trunc_cnt are tied to 0.
module stash_op1_out
    import stash_pkg::*;
#(
    parameter int         C_M_AXIS_DATA_WIDTH  = 256,
    parameter int         C_M_AXIS_TUSER_WIDTH = 128,
    parameter int         MAX_BEATS            = 64,
    parameter logic [7:0] DST_PORT_ONEHOT      = DST_PORT_OP1
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic                              i_pkt_fifo_empty,
    output logic                              o_pkt_fifo_rd_en,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]    i_tdata_fifo,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]   i_tuser_fifo,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  i_tkeep_fifo,
    input  logic                              i_tlast_fifo,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    o_m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  o_m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   o_m_axis_tuser,
    output logic                              o_m_axis_tvalid,
    output logic                              o_m_axis_tlast,
    input  logic                              i_m_axis_tready,
    output logic [31:0]                       o_pkt_cnt,
    output logic [31:0]                       o_trunc_cnt,
    output logic [1:0]                        o_dbg_state
);

    localparam int KEEP_W = C_M_AXIS_DATA_WIDTH / 8;
    localparam int BEAT_W = C_M_AXIS_DATA_WIDTH + C_M_AXIS_TUSER_WIDTH + KEEP_W + 1;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);

    state_t                            state;
    state_t                            state_nxt;
    logic [CNT_W-1:0]                  beat_cnt;
    logic [CNT_W-1:0]                  beat_cnt_nxt;
    logic                              run;
    logic                              skid_full;
    logic                              fwd;
    logic                              fwd_last;
    logic                              trunc;
    logic [C_M_AXIS_TUSER_WIDTH-1:0]   tuser_fwd;

    // Pops only depend on registered state and FIFO status, never on tready.
    // run keeps rd_en low while reset is asserted.
    assign o_pkt_fifo_rd_en = run && !i_pkt_fifo_empty
                              && (state == ST_DROP || !skid_full);
    assign o_dbg_state = state;

    // Next state, beat counter and the beat presented to the output buffer
    always_comb begin
        state_nxt    = state;
        beat_cnt_nxt = beat_cnt;
        fwd          = 1'b0;
        fwd_last     = i_tlast_fifo;
        trunc        = 1'b0;
        tuser_fwd    = i_tuser_fifo;
        case (state)
            ST_IDLE: begin
                beat_cnt_nxt = '0;
                if (o_pkt_fifo_rd_en) begin
                    fwd = 1'b1;
                    tuser_fwd[TUSER_DST_HI:TUSER_DST_LO] = DST_PORT_ONEHOT;
                    if (!i_tlast_fifo) begin
                        state_nxt    = ST_FWD;
                        beat_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            ST_FWD: begin
                if (o_pkt_fifo_rd_en) begin
                    fwd = 1'b1;
                    if (i_tlast_fifo) begin
                        state_nxt    = ST_IDLE;
                        beat_cnt_nxt = '0;
                    end else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
                        fwd_last     = 1'b1;
                        trunc        = 1'b1;
                        state_nxt    = ST_DROP;
                        beat_cnt_nxt = '0;
                    end else begin
                        beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DROP: begin
                beat_cnt_nxt = '0;
                if (o_pkt_fifo_rd_en && i_tlast_fifo) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                beat_cnt_nxt = '0;
            end
        endcase
    end

    // State register, beat counter and post-reset run flag
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state    <= ST_IDLE;
            beat_cnt <= '0;
            run      <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_cnt_nxt;
            run      <= 1'b1;
        end
    end

    logic [BEAT_W-1:0] out_beat;

    axis_skid_reg #(
        .WIDTH(BEAT_W)
    ) u_skid (
        .clk       (axis_aclk),
        .rst       (axis_reset),
        .in_valid  (fwd),
        .in_data   ({i_tdata_fifo, tuser_fwd, i_tkeep_fifo, fwd_last}),
        .skid_full (skid_full),
        .out_valid (o_m_axis_tvalid),
        .out_data  (out_beat),
        .out_ready (i_m_axis_tready)
    );

    assign {o_m_axis_tdata, o_m_axis_tuser, o_m_axis_tkeep, o_m_axis_tlast} = out_beat;

`ifdef STASH_OP1_OUT_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] trunc_cnt;

    // Wrapping counters: delivered packets and FWD->DROP truncations
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            pkt_cnt   <= '0;
            trunc_cnt <= '0;
        end else begin
            if (o_m_axis_tvalid && i_m_axis_tready && o_m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (trunc) begin
                trunc_cnt <= trunc_cnt + 32'd1;
            end
        end
    end

    assign o_pkt_cnt   = pkt_cnt;
    assign o_trunc_cnt = trunc_cnt;
`else
    assign o_pkt_cnt   = '0;
    assign o_trunc_cnt = '0;
`endif

endmodule

// File: tb/tb_stash_op1_out.sv
// Bench for stash_op1_out. A FIFO model feeds the DUT; each generated packet
// is turned into its expected output beats at generation time (first-beat
// destination rewrite, truncation to MAX_BEATS with forced tlast) and queued
// in exp_q. A beat-occupancy count derived from pops and handshakes gives the
// expected tvalid and rd_en behaviour each cycle.
module tb_stash_op1_out;

    localparam int D    = 256;
    localparam int U    = 128;
    localparam int K    = D / 8;
    localparam int MAXB = 64;
    localparam int W    = D + U + K + 1;

    logic          axis_aclk;
    logic          axis_reset;
    logic          i_pkt_fifo_empty;
    logic          o_pkt_fifo_rd_en;
    logic [D-1:0]  i_tdata_fifo;
    logic [U-1:0]  i_tuser_fifo;
    logic [K-1:0]  i_tkeep_fifo;
    logic          i_tlast_fifo;
    logic [D-1:0]  o_m_axis_tdata;
    logic [K-1:0]  o_m_axis_tkeep;
    logic [U-1:0]  o_m_axis_tuser;
    logic          o_m_axis_tvalid;
    logic          o_m_axis_tlast;
    logic          i_m_axis_tready;
    logic [31:0]   o_pkt_cnt;
    logic [31:0]   o_trunc_cnt;
    logic [1:0]    o_dbg_state;

    stash_op1_out #(
        .C_M_AXIS_DATA_WIDTH (D),
        .C_M_AXIS_TUSER_WIDTH(U),
        .MAX_BEATS           (MAXB),
        .DST_PORT_ONEHOT     (8'h04)
    ) dut (
        .axis_aclk       (axis_aclk),
        .axis_reset      (axis_reset),
        .i_pkt_fifo_empty(i_pkt_fifo_empty),
        .o_pkt_fifo_rd_en(o_pkt_fifo_rd_en),
        .i_tdata_fifo    (i_tdata_fifo),
        .i_tuser_fifo    (i_tuser_fifo),
        .i_tkeep_fifo    (i_tkeep_fifo),
        .i_tlast_fifo    (i_tlast_fifo),
        .o_m_axis_tdata  (o_m_axis_tdata),
        .o_m_axis_tkeep  (o_m_axis_tkeep),
        .o_m_axis_tuser  (o_m_axis_tuser),
        .o_m_axis_tvalid (o_m_axis_tvalid),
        .o_m_axis_tlast  (o_m_axis_tlast),
        .i_m_axis_tready (i_m_axis_tready),
        .o_pkt_cnt       (o_pkt_cnt),
        .o_trunc_cnt     (o_trunc_cnt),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    // Hard time limit
    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

    // ---------------- model state ----------------
    typedef struct {
        logic [D-1:0] data;
        logic [U-1:0] user;
        logic [K-1:0] keep;
        logic         last;
        bit           fwd;
        int           gap;
    } fbeat_t;

    fbeat_t      fifo_q[$];
    logic [W-1:0] exp_q[$];

    int          errors = 0;
    int          checks = 0;
    int          occ = 0;
    int          out_cnt = 0;
    int          exp_pkt = 0;
    int          exp_trunc = 0;
    int          tready_mode = 0;
    bit          prev_stall = 0;
    logic [W-1:0] prev_beat = '0;

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- packet generator / reference ----------------
    task automatic gen_packet(input int len, input int dst, input int gap_idx, input int gap_len);
        fbeat_t       b;
        logic [U-1:0] ouser;
        logic         olast;
        logic [K-1:0] ones;
        ones = '1;
        for (int i = 0; i < len; i++) begin
            for (int j = 0; j < D / 32; j++) b.data[j*32 +: 32] = $urandom();
            for (int j = 0; j < U / 32; j++) b.user[j*32 +: 32] = $urandom();
            if (i == 0 && dst >= 0) b.user[31:24] = 8'(dst);
            b.last = (i == len - 1);
            b.keep = b.last ? (ones >> $urandom_range(0, K - 1)) : ones;
            b.fwd  = (i < MAXB);
            b.gap  = (i == gap_idx) ? gap_len : 0;
            fifo_q.push_back(b);
            if (i < MAXB) begin
                ouser = b.user;
                if (i == 0) ouser[31:24] = 8'h04;
                olast = (i == len - 1) || (i == MAXB - 1);
                exp_q.push_back({b.data, ouser, b.keep, olast});
            end
        end
        exp_pkt++;
        if (len > MAXB) exp_trunc++;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        if (fifo_q.size() > 0) begin
            i_pkt_fifo_empty = (fifo_q[0].gap > 0);
            i_tdata_fifo     = fifo_q[0].data;
            i_tuser_fifo     = fifo_q[0].user;
            i_tkeep_fifo     = fifo_q[0].keep;
            i_tlast_fifo     = fifo_q[0].last;
        end else begin
            i_pkt_fifo_empty = 1'b1;
            i_tdata_fifo     = '0;
            i_tuser_fifo     = '0;
            i_tkeep_fifo     = '0;
            i_tlast_fifo     = 1'b0;
        end
        case (tready_mode)
            0:       i_m_axis_tready = 1'b1;
            1:       i_m_axis_tready = ~i_m_axis_tready;
            2:       i_m_axis_tready = 1'($urandom_range(0, 1));
            default: i_m_axis_tready = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    // One clock: check at negedge, advance model after posedge, redrive
    task automatic step();
        logic [W-1:0] got;
        bit           fire_pop;
        bit           fire_out;
        bit           head_fwd;
        fbeat_t       hb;
        @(negedge axis_aclk);
        got      = {o_m_axis_tdata, o_m_axis_tuser, o_m_axis_tkeep, o_m_axis_tlast};
        head_fwd = (fifo_q.size() > 0) && fifo_q[0].fwd;
        check_val("tvalid", W'(o_m_axis_tvalid), W'(occ > 0));
        if (prev_stall) begin
            check_val("stall_valid", W'(o_m_axis_tvalid), W'(1'b1));
            check_val("stall_beat", got, prev_beat);
        end
        if (!i_pkt_fifo_empty) begin
            check_val("rd_en", W'(o_pkt_fifo_rd_en), W'(head_fwd ? (occ < 2) : 1'b1));
        end else begin
            check_val("rd_en_empty", W'(o_pkt_fifo_rd_en), W'(1'b0));
        end
        fire_pop = o_pkt_fifo_rd_en && !i_pkt_fifo_empty;
        fire_out = o_m_axis_tvalid && i_m_axis_tready;
        if (fire_out) begin
            check_val("beat_avail", W'(exp_q.size() > 0), W'(1'b1));
            if (exp_q.size() > 0) check_val("beat", got, exp_q.pop_front());
        end
        prev_stall = o_m_axis_tvalid && !i_m_axis_tready;
        prev_beat  = got;
        @(posedge axis_aclk);
        #1;
        if (fire_pop) begin
            if (fifo_q[0].fwd) occ++;
            fifo_q.delete(0);
        end else if (fifo_q.size() > 0 && fifo_q[0].gap > 0) begin
            hb = fifo_q[0];
            hb.gap--;
            fifo_q[0] = hb;
        end
        if (fire_out) begin
            occ--;
            out_cnt++;
        end
        drive();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() > 0 || occ > 0) && n < budget) begin
            step();
            n++;
        end
        check_val("drain_timeout", W'(fifo_q.size() + occ), W'(0));
        check_val("exp_left", W'(exp_q.size()), W'(0));
        step();
    endtask

    task automatic check_stats();
`ifdef STASH_OP1_OUT_STATS_EN
        check_val("pkt_cnt", W'(o_pkt_cnt), W'(32'(exp_pkt)));
        check_val("trunc_cnt", W'(o_trunc_cnt), W'(32'(exp_trunc)));
`else
        check_val("pkt_cnt_tied", W'(o_pkt_cnt), W'(32'(0)));
        check_val("trunc_cnt_tied", W'(o_trunc_cnt), W'(32'(0)));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tvalid"}, W'(o_m_axis_tvalid), W'(1'b0));
        check_val({tag, "_tdata"}, W'(o_m_axis_tdata), W'(0));
        check_val({tag, "_tuser"}, W'(o_m_axis_tuser), W'(0));
        check_val({tag, "_tkeep"}, W'(o_m_axis_tkeep), W'(0));
        check_val({tag, "_tlast"}, W'(o_m_axis_tlast), W'(1'b0));
        check_val({tag, "_rd_en"}, W'(o_pkt_fifo_rd_en), W'(1'b0));
        check_val({tag, "_pkt_cnt"}, W'(o_pkt_cnt), W'(32'(0)));
        check_val({tag, "_state"}, W'(o_dbg_state), W'(2'd0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int len;
        int base;
        int n;
        axis_reset       = 1'b1;
        i_m_axis_tready  = 1'b1;
        i_pkt_fifo_empty = 1'b0;
        i_tdata_fifo     = {8{32'hdeadbeef}};
        i_tuser_fifo     = {4{32'h12345678}};
        i_tkeep_fifo     = '1;
        i_tlast_fifo     = 1'b0;
        repeat (3) @(posedge axis_aclk);
        #2;
        check_reset_outputs("reset");
        i_pkt_fifo_empty = 1'b1;
        @(negedge axis_aclk);
        axis_reset = 1'b0;
        repeat (2) @(posedge axis_aclk);
        #1;
        drive();

        // 3-beat packet, tready always high
        tready_mode = 0;
        gen_packet(3, 8'h01, -1, 0);
        drain(100);
        check_stats();

        // same packet shape, tready toggling
        tready_mode = 1;
        gen_packet(3, 8'h01, -1, 0);
        drain(100);
        check_stats();

        // 70-beat packet truncated to MAX_BEATS, then a 2-beat packet
        tready_mode = 3;
        gen_packet(70, -1, -1, 0);
        gen_packet(2, -1, -1, 0);
        drain(600);
        check_stats();
        check_val("state_after_trunc", W'(o_dbg_state), W'(2'd0));

        // one-beat packet
        tready_mode = 0;
        gen_packet(1, 8'h01, -1, 0);
        drain(50);
        check_val("state_one_beat", W'(o_dbg_state), W'(2'd0));

        // 5-cycle FIFO gap mid-packet
        gen_packet(10, -1, 4, 5);
        drain(100);
        check_stats();

        // randomized packets, two backpressure profiles
        for (int batch = 0; batch < 2; batch++) begin
            tready_mode = 2 + batch;
            for (int p = 0; p < 12; p++) begin
                len = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 8);
                gen_packet(len, -1, ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1,
                           $urandom_range(1, 4));
            end
            drain(6000);
            check_stats();
        end

        // reset asserted after two beats of a 6-beat packet
        tready_mode = 0;
        gen_packet(6, -1, -1, 0);
        base = out_cnt;
        n = 0;
        while (out_cnt < base + 2 && n < 50) begin
            step();
            n++;
        end
        check_val("reset_pre_beats", W'(out_cnt - base), W'(2));
        #2;
        axis_reset = 1'b1;
        #1;
        check_reset_outputs("mid_reset");
        fifo_q.delete();
        exp_q.delete();
        occ        = 0;
        prev_stall = 0;
        exp_pkt    = 0;
        exp_trunc  = 0;
        drive();
        @(negedge axis_aclk);
        axis_reset = 1'b0;
        repeat (2) @(posedge axis_aclk);
        #1;
        drive();
        gen_packet(3, 8'h01, -1, 0);
        drain(100);
        check_stats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
